sbpu_redirect_ctrl: RTL and testbench

Fetch-redirect sequencer between the static branch predictor, the EXU and the IFU. It accepts taken predictions and records each one in a small in-order tracking FIFO. It checks EXU resolutions against the recorded targets and arbitrates prediction, mispredict and flush redirects onto a single valid/ready redirect channel toward the IFU.

---
 rtl/alioth_bpu_pkg.sv | 29 ++
 rtl/bpu_track_fifo.sv | 47 ++++
 rtl/sbpu_redirect_ctrl.sv | 153 +++++++++++++++
 tb/tb_sbpu_redirect_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alioth_bpu_pkg.sv
// Shared types for the branch-prediction unit: redirect causes, redirect
// sequencer states and the tracking-FIFO entry layout.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package alioth_bpu_pkg;

   localparam int ADDR_W = `INST_ADDR_WIDTH;

   typedef enum logic [1:0] {
      CAUSE_PRED    = 2'd0,
      CAUSE_MISPRED = 2'd1,
      CAUSE_FLUSH   = 2'd2
   } redirect_cause_e;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PEND_PRED  = 2'd1,
      PEND_FLUSH = 2'd2,
      DRAIN      = 2'd3
   } redir_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [ADDR_W-1:0] target;
   } pred_entry_t;

endpackage

// File: rtl/bpu_track_fifo.sv
// In-order tracking FIFO for outstanding taken predictions.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Clear has priority over push and pop.
module bpu_track_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]  wr_ptr, rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push, do_pop;

   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign head    = mem[rd_ptr[PW-1:0]];

   // Pointer update; clear and reset both empty the FIFO.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // Entry storage; data is not reset, only the pointers are.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
   end

endmodule

// File: rtl/sbpu_redirect_ctrl.sv
// Fetch-redirect sequencer: tracks accepted taken predictions, checks EXU
// resolutions against their targets and arbitrates prediction, mispredict
// and flush redirects onto one valid/ready channel toward the IFU.
// Optional macro SBPU_REDIRECT_PERF_EN adds prediction/mispredict counters.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module sbpu_redirect_ctrl
   import alioth_bpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = `INST_ADDR_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pred_req_i,
   input  logic [AW-1:0] pred_pc_i,
   input  logic [AW-1:0] pred_addr_i,
   output logic          pred_ready_o,
   input  logic          resolve_valid_i,
   input  logic [AW-1:0] resolve_npc_i,
   input  logic          flush_i,
   input  logic [AW-1:0] flush_addr_i,
   output logic          redirect_valid_o,
   output logic [AW-1:0] redirect_addr_o,
   output logic [1:0]    redirect_cause_o,
   input  logic          redirect_ready_i,
   output logic          fifo_full_o,
   output logic          resolve_err_o,
   output logic [31:0]   pred_cnt_o,
   output logic [31:0]   mispred_cnt_o
);

   redir_state_e    state_q, state_d;
   redirect_cause_e cause_q, cause_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            valid_q, err_q;

   logic [2*AW-1:0] head;
   logic [AW-1:0]   head_target;
   logic            unused_head_pc;
   logic            fifo_full, fifo_empty;
   logic            resolve_pop, mispred, accept, fifo_clear;

   // The PC half of an entry is carried for debug visibility only.
   assign head_target    = head[AW-1:0];
   assign unused_head_pc = ^head[2*AW-1:AW];

   assign resolve_pop  = resolve_valid_i && !fifo_empty;
   assign mispred      = resolve_pop && (resolve_npc_i != head_target);
   assign pred_ready_o = pred_req_i && (state_q == IDLE) && !fifo_full && !flush_i && !mispred;
   assign accept       = pred_ready_o;
   assign fifo_clear   = flush_i || mispred;

   bpu_track_fifo #(
      .DEPTH (DEPTH),
      .W     (2*AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (resolve_pop),
      .clear (fifo_clear),
      .wdata ({pred_pc_i, pred_addr_i}),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and redirect latch: flush beats mispredict beats prediction.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cause_d = cause_q;
      if (flush_i) begin
         state_d = PEND_FLUSH;
         addr_d  = flush_addr_i;
         cause_d = CAUSE_FLUSH;
      end else if (mispred) begin
         state_d = PEND_FLUSH;
         addr_d  = resolve_npc_i;
         cause_d = CAUSE_MISPRED;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d = PEND_PRED;
                  addr_d  = pred_addr_i;
                  cause_d = CAUSE_PRED;
               end
            end
            PEND_PRED:  if (redirect_ready_i) state_d = IDLE;
            PEND_FLUSH: if (redirect_ready_i) state_d = DRAIN;
            DRAIN:      state_d = IDLE;
            default:    state_d = IDLE;
         endcase
      end
   end

   // Registered redirect channel; valid whenever a redirect is pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         cause_q <= CAUSE_PRED;
      end else begin
         valid_q <= (state_d == PEND_PRED) || (state_d == PEND_FLUSH);
         addr_q  <= addr_d;
         cause_q <= cause_d;
      end
   end

   // Sticky error: a resolve arrived with nothing outstanding.
   always_ff @(posedge clk) begin
      if (rst)                              err_q <= 1'b0;
      else if (resolve_valid_i && fifo_empty) err_q <= 1'b1;
   end

   assign redirect_valid_o = valid_q;
   assign redirect_addr_o  = addr_q;
   assign redirect_cause_o = cause_q;
   assign fifo_full_o      = fifo_full;
   assign resolve_err_o    = err_q;

`ifdef SBPU_REDIRECT_PERF_EN
   logic [31:0] pred_cnt_q, mispred_cnt_q;

   // Performance counters; a mispredict hidden by a same-cycle flush is not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_cnt_q    <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (accept)              pred_cnt_q    <= pred_cnt_q + 32'd1;
         if (mispred && !flush_i) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign pred_cnt_o    = pred_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;
`else
   assign pred_cnt_o    = 32'd0;
   assign mispred_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_sbpu_redirect_ctrl.sv
// Directed bench for sbpu_redirect_ctrl (DEPTH=4, AW=32).
module tb_sbpu_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        pred_req_i;
   logic [31:0] pred_pc_i, pred_addr_i;
   logic        pred_ready_o;
   logic        resolve_valid_i;
   logic [31:0] resolve_npc_i;
   logic        flush_i;
   logic [31:0] flush_addr_i;
   logic        redirect_valid_o;
   logic [31:0] redirect_addr_o;
   logic [1:0]  redirect_cause_o;
   logic        redirect_ready_i;
   logic        fifo_full_o;
   logic        resolve_err_o;
   logic [31:0] pred_cnt_o, mispred_cnt_o;

   int tests = 0;
   int fails = 0;

   sbpu_redirect_ctrl #(.DEPTH(4), .AW(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .pred_req_i       (pred_req_i),
      .pred_pc_i        (pred_pc_i),
      .pred_addr_i      (pred_addr_i),
      .pred_ready_o     (pred_ready_o),
      .resolve_valid_i  (resolve_valid_i),
      .resolve_npc_i    (resolve_npc_i),
      .flush_i          (flush_i),
      .flush_addr_i     (flush_addr_i),
      .redirect_valid_o (redirect_valid_o),
      .redirect_addr_o  (redirect_addr_o),
      .redirect_cause_o (redirect_cause_o),
      .redirect_ready_i (redirect_ready_i),
      .fifo_full_o      (fifo_full_o),
      .resolve_err_o    (resolve_err_o),
      .pred_cnt_o       (pred_cnt_o),
      .mispred_cnt_o    (mispred_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_redir(input string tag, input logic v, input logic [31:0] a, input logic [1:0] c);
      chk({tag, "_valid"}, 32'(redirect_valid_o), 32'(v));
      chk({tag, "_addr"},  redirect_addr_o, a);
      chk({tag, "_cause"}, 32'(redirect_cause_o), 32'(c));
   endtask

   localparam logic [1:0] PRED = 2'd0, MISP = 2'd1, FLSH = 2'd2;

   logic [31:0] exp_pcnt, exp_mcnt;

   initial begin
      rst = 1'b1; pred_req_i = 1'b0; pred_pc_i = '0; pred_addr_i = '0;
      resolve_valid_i = 1'b0; resolve_npc_i = '0; flush_i = 1'b0; flush_addr_i = '0;
      redirect_ready_i = 1'b0;
      tick(); tick();
      // reset state
      chk_redir("rst", 1'b0, 32'h0, PRED);
      chk("rst_full", 32'(fifo_full_o), 32'd0);
      chk("rst_err", 32'(resolve_err_o), 32'd0);
      chk("rst_pcnt", pred_cnt_o, 32'd0);
      chk("rst_mcnt", mispred_cnt_o, 32'd0);
      rst = 1'b0;
      tick();

      // accept and handshake with ready low for 3 cycles
      pred_req_i = 1'b1; pred_pc_i = 32'h8000_00F0; pred_addr_i = 32'h8000_0100;
      #1;
      chk("acc_ready", 32'(pred_ready_o), 32'd1);
      tick();
      pred_req_i = 1'b0;
      chk_redir("hold1", 1'b1, 32'h8000_0100, PRED);
      tick();
      chk_redir("hold2", 1'b1, 32'h8000_0100, PRED);
      pred_req_i = 1'b1; pred_addr_i = 32'h8000_0999;
      #1;
      chk("pendpred_block", 32'(pred_ready_o), 32'd0);
      pred_req_i = 1'b0;
      tick();
      chk_redir("hold3", 1'b1, 32'h8000_0100, PRED);
      redirect_ready_i = 1'b1;
      tick();
      chk("hs_drop", 32'(redirect_valid_o), 32'd0);

      // fill the FIFO with three more predictions
      for (int i = 1; i <= 3; i++) begin
         pred_req_i = 1'b1; pred_addr_i = 32'h8000_0100 + 32'(i * 16);
         #1;
         chk("fill_ready", 32'(pred_ready_o), 32'd1);
         tick();
         pred_req_i = 1'b0;
         tick();
      end
      chk("full_set", 32'(fifo_full_o), 32'd1);
      pred_req_i = 1'b1; pred_addr_i = 32'h8000_0140;
      #1;
      chk("full_block", 32'(pred_ready_o), 32'd0);
      tick();
      pred_req_i = 1'b0;
      chk("full_noredir", 32'(redirect_valid_o), 32'd0);

      // correct resolve pops the head, no redirect
      resolve_valid_i = 1'b1; resolve_npc_i = 32'h8000_0100;
      tick();
      resolve_valid_i = 1'b0;
      chk("ok_noredir", 32'(redirect_valid_o), 32'd0);
      chk("ok_notfull", 32'(fifo_full_o), 32'd0);

      // same-cycle correct pop and push keeps occupancy at 3
      resolve_valid_i = 1'b1; resolve_npc_i = 32'h8000_0110;
      pred_req_i = 1'b1; pred_addr_i = 32'h8000_0140;
      #1;
      chk("pp_ready", 32'(pred_ready_o), 32'd1);
      tick();
      resolve_valid_i = 1'b0; pred_req_i = 1'b0;
      chk_redir("pp", 1'b1, 32'h8000_0140, PRED);
      chk("pp_notfull", 32'(fifo_full_o), 32'd0);
      tick();

      // flush clears the FIFO, then walk through DRAIN
      flush_i = 1'b1; flush_addr_i = 32'h8000_1000;
      tick();
      flush_i = 1'b0;
      chk_redir("flush", 1'b1, 32'h8000_1000, FLSH);
      tick();
      chk("flush_drain", 32'(redirect_valid_o), 32'd0);
      tick();

      // mispredict: head 0x8000_0040, actual 0x8000_0044
      pred_req_i = 1'b1; pred_addr_i = 32'h8000_0040;
      tick();
      pred_req_i = 1'b0;
      tick();
      resolve_valid_i = 1'b1; resolve_npc_i = 32'h8000_0044;
      tick();
      resolve_valid_i = 1'b0;
      chk_redir("misp", 1'b1, 32'h8000_0044, MISP);
`ifdef SBPU_REDIRECT_PERF_EN
      exp_pcnt = 32'd6; exp_mcnt = 32'd1;
`else
      exp_pcnt = 32'd0; exp_mcnt = 32'd0;
`endif
      chk("pcnt", pred_cnt_o, exp_pcnt);
      chk("mcnt", mispred_cnt_o, exp_mcnt);
      tick();
      chk("misp_drop", 32'(redirect_valid_o), 32'd0);
      pred_req_i = 1'b1; pred_addr_i = 32'h8000_0200;
      #1;
      chk("drain_block", 32'(pred_ready_o), 32'd0);
      tick();
      chk("drain_noredir", 32'(redirect_valid_o), 32'd0);
      chk("idle_ready", 32'(pred_ready_o), 32'd1);
      redirect_ready_i = 1'b0;
      tick();
      pred_req_i = 1'b0;
      chk_redir("acc200", 1'b1, 32'h8000_0200, PRED);

      // collision in PEND_PRED: flush beats a mispredicting resolve
      flush_i = 1'b1; flush_addr_i = 32'h8000_0000;
      resolve_valid_i = 1'b1; resolve_npc_i = 32'h8000_0204;
      tick();
      flush_i = 1'b0; resolve_valid_i = 1'b0;
      chk_redir("coll", 1'b1, 32'h8000_0000, FLSH);
      chk("coll_mcnt", mispred_cnt_o, exp_mcnt);

      // newer flush overwrites while pending, then holds stable
      flush_i = 1'b1; flush_addr_i = 32'h8000_0800;
      tick();
      flush_i = 1'b0;
      chk_redir("reflush", 1'b1, 32'h8000_0800, FLSH);
      tick();
      chk_redir("stable", 1'b1, 32'h8000_0800, FLSH);

      // resolve with FIFO empty sets the sticky error only
      resolve_valid_i = 1'b1; resolve_npc_i = 32'h1234_5678;
      tick();
      resolve_valid_i = 1'b0;
      chk("err_set", 32'(resolve_err_o), 32'd1);
      chk_redir("err_noredir", 1'b1, 32'h8000_0800, FLSH);
      tick();
      chk("err_sticky", 32'(resolve_err_o), 32'd1);

      // reset mid-PEND_FLUSH clears everything on the next edge
      rst = 1'b1;
      tick();
      chk_redir("rst2", 1'b0, 32'h0, PRED);
      chk("rst2_err", 32'(resolve_err_o), 32'd0);
      chk("rst2_full", 32'(fifo_full_o), 32'd0);
      chk("rst2_pcnt", pred_cnt_o, 32'd0);
      chk("rst2_mcnt", mispred_cnt_o, 32'd0);
      rst = 1'b0;
      pred_req_i = 1'b1; pred_addr_i = 32'h8000_0300;
      #1;
      chk("rst2_ready", 32'(pred_ready_o), 32'd1);
      tick();
      pred_req_i = 1'b0;
      chk_redir("rst2_acc", 1'b1, 32'h8000_0300, PRED);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
